// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - screen codes shared by the screen sequencer and the VGA mux select decode
//  SCR_W     : width of a screen code
//  screen_t  : screen code type (vga_control value)
//  SCR_*     : screen codes OFF=0, INTRO=1, MENU=2, GAME=3, SCORE=4
package screen_pkg;

    localparam int SCR_W = 4;

    typedef logic [SCR_W-1:0] screen_t;

    localparam screen_t SCR_OFF   = 4'd0;
    localparam screen_t SCR_INTRO = 4'd1;
    localparam screen_t SCR_MENU  = 4'd2;
    localparam screen_t SCR_GAME  = 4'd3;
    localparam screen_t SCR_SCORE = 4'd4;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - button synchronizer plus rising-edge detector
//  clk   in  system clock
//  clr   in  asynchronous active-low reset
//  din   in  raw button level, asynchronous to clk
//  pulse out one-cycle pulse per synchronized low-to-high transition
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Combinational so the FSM acts on the edge one clock after the last sync stage:
    // the raw edge reaches the state register on edge SYNC_STAGES+1.
    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/screen_ctrl.sv
// rtl/screen_ctrl.sv - screen sequencer driving the VGA mux select and INTRO blink
//  clk         in   system clock
//  clr         in   asynchronous active-low reset
//  en          in   display enable; 0 forces OFF
//  btn_start   in   raw start button, async to clk
//  btn_back    in   raw back button, async to clk
//  game_over   in   game finished level, sync to clk
//  vga_control out  screen select (state code)
//  blink       out  1 = blank the INTRO image
//  game_rst    out  one-cycle pulse on GAME entry
module screen_ctrl
    import screen_pkg::*;
#(
    parameter int unsigned BLINK_HALF  = 25_000_000,
    parameter int unsigned INTRO_TICKS = 300_000_000,
    parameter int unsigned SCORE_TICKS = 500_000_000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             btn_start,
    input  logic             btn_back,
    input  logic             game_over,
    output logic [SCR_W-1:0] vga_control,
    output logic             blink,
    output logic             game_rst
);

    localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);
    localparam logic [31:0] INTRO_LAST = 32'(INTRO_TICKS - 1);
    localparam logic [31:0] SCORE_LAST = 32'(SCORE_TICKS - 1);

    logic start_pulse;
    logic back_pulse;

    screen_t     state_q, state_d;
    logic [31:0] dwell_q, dwell_d;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;
    logic        game_rst_q, game_rst_d;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (
        .clk   (clk),
        .clr   (clr),
        .din   (btn_start),
        .pulse (start_pulse)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_back (
        .clk   (clk),
        .clr   (clr),
        .din   (btn_back),
        .pulse (back_pulse)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= SCR_OFF;
            dwell_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            game_rst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            game_rst_q  <= game_rst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = SCR_OFF;
        end else begin
            case (state_q)
                SCR_OFF:   state_d = SCR_INTRO;
                SCR_INTRO: if (start_pulse || dwell_q == INTRO_LAST) state_d = SCR_MENU;
                // start wins over back when both arrive together
                SCR_MENU:  if (start_pulse)     state_d = SCR_GAME;
                           else if (back_pulse) state_d = SCR_INTRO;
                SCR_GAME:  if (game_over)       state_d = SCR_SCORE;
                           else if (back_pulse) state_d = SCR_MENU;
                SCR_SCORE: if (start_pulse || dwell_q == SCORE_LAST) state_d = SCR_MENU;
                default:   state_d = SCR_OFF;
            endcase
        end
    end

    always_comb begin
        dwell_d = '0;
        if (state_d == state_q) begin
            dwell_d = (dwell_q == '1) ? dwell_q : dwell_q + 32'd1;
        end
    end

    // Blink counter only runs while staying in INTRO; entry and every other state hold it cleared.
    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (state_d == SCR_INTRO && state_q == SCR_INTRO) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 32'd1;
                blink_d     = blink_q;
            end
        end
    end

    assign game_rst_d = (state_d == SCR_GAME) && (state_q != SCR_GAME);

    assign vga_control = state_q;
    assign blink       = blink_q;
    assign game_rst    = game_rst_q;

endmodule

// File: tb/tb_screen_ctrl.sv
// tb/tb_screen_ctrl.sv - scoreboard bench for screen_ctrl against a cycle-count reference model
module tb_screen_ctrl;

    localparam int BH = 4;
    localparam int IT = 20;
    localparam int ST = 10;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_back = 1'b0;
    logic       game_over = 1'b0;
    logic [3:0] vga_control;
    logic       blink;
    logic       game_rst;

    screen_ctrl #(
        .BLINK_HALF  (BH),
        .INTRO_TICKS (IT),
        .SCORE_TICKS (ST),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .en          (en),
        .btn_start   (btn_start),
        .btn_back    (btn_back),
        .game_over   (game_over),
        .vga_control (vga_control),
        .blink       (blink),
        .game_rst    (game_rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        int vga;
        int blk;
        int grst;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: screen number, cycles spent in it, and raw button samples per edge.
    int m_st;
    int m_k;
    int hs[$];
    int hb[$];

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = 0;
        m_k  = 0;
        hs   = {};
        hb   = {};
        for (int i = 0; i < SS + 1; i++) begin
            hs.push_back(0);
            hb.push_back(0);
        end
    endfunction

    // A raw rise sampled at edge n acts at edge n+SS.
    function automatic int pulse_of(input int h[$]);
        return (h[h.size()-SS] == 1 && h[h.size()-SS-1] == 0) ? 1 : 0;
    endfunction

    // Called at a negedge: drive inputs, predict the next edge, advance to the next negedge.
    task automatic step(input int e, input int s, input int b, input int g);
        int   ps, pb, nx;
        exp_t x;
        en        = e[0];
        btn_start = s[0];
        btn_back  = b[0];
        game_over = g[0];
        ps = pulse_of(hs);
        pb = pulse_of(hb);
        hs.push_back(s);
        hb.push_back(b);
        if (hs.size() > 8) begin
            void'(hs.pop_front());
            void'(hb.pop_front());
        end
        nx = m_st;
        if (e == 0) nx = 0;
        else case (m_st)
            0: nx = 1;
            1: nx = (ps == 1 || m_k == IT - 1) ? 2 : 1;
            2: nx = (ps == 1) ? 3 : ((pb == 1) ? 1 : 2);
            3: nx = (g == 1) ? 4 : ((pb == 1) ? 2 : 3);
            4: nx = (ps == 1 || m_k == ST - 1) ? 2 : 4;
            default: nx = 0;
        endcase
        x.grst = (nx == 3 && m_st != 3) ? 1 : 0;
        m_k    = (nx != m_st) ? 0 : m_k + 1;
        m_st   = nx;
        x.vga  = m_st;
        x.blk  = (m_st == 1) ? ((m_k / BH) % 2) : 0;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("vga_control", int'(vga_control), x.vga);
                chk("blink", int'(blink), x.blk);
                chk("game_rst", int'(game_rst), x.grst);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, b;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_vga", int'(vga_control), 0);
        chk("reset_blink", int'(blink), 0);
        chk("reset_grst", int'(game_rst), 0);
        clr = 1'b1;

        // OFF held, then INTRO with blink run and auto-advance to MENU
        repeat (4) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("intro_entry", int'(vga_control), 1);
        repeat (20) step(1, 0, 0, 0);
        chk("intro_dwell_menu", int'(vga_control), 2);

        // held start: one transition only
        repeat (100) step(1, 1, 0, 0);
        chk("held_start_game", int'(vga_control), 3);
        repeat (3) step(1, 0, 0, 0);

        // game_over and back together -> SCORE, then dwell back to MENU
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 1);
        chk("over_and_back_score", int'(vga_control), 4);
        repeat (10) step(1, 0, 0, 0);
        chk("score_dwell_menu", int'(vga_control), 2);

        // start and back together in MENU -> GAME; en drop -> OFF
        repeat (3) step(1, 1, 1, 0);
        chk("start_and_back_game", int'(vga_control), 3);
        step(0, 0, 0, 0);
        chk("en_drop_off", int'(vga_control), 0);

        // back to GAME for the mid-GAME reset
        step(1, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        chk("game_entry_pulse", int'(game_rst), 1);
        #2;
        clr = 1'b0;
        #1;
        chk("async_clr_vga", int'(vga_control), 0);
        chk("async_clr_grst", int'(game_rst), 0);
        chk("async_clr_blink", int'(blink), 0);
        model_reset();
        btn_start = 1'b0;
        @(negedge clk);
        clr = 1'b1;

        // randomized traffic
        s = 0;
        b = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) s = 1 - s;
            if ($urandom_range(0, 7) == 0) b = 1 - b;
            step(($urandom_range(0, 39) != 0) ? 1 : 0, s, b,
                 ($urandom_range(0, 9) == 0) ? 1 : 0);
        end

        // illegal state code recovers to OFF
        en = 1'b1;
        force dut.state_q = 4'd7;
        #1;
        release dut.state_q;
        chk("illegal_forced", int'(vga_control), 7);
        @(posedge clk);
        #1;
        chk("illegal_to_off", int'(vga_control), 0);
        chk("illegal_grst", int'(game_rst), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
